lsu_mem_port: RTL
=================

# lsu_mem_port

Multi-cycle load/store unit that consumes the effective address produced by the execute stage and drives the data-memory bus. It handles byte-lane steering, sign/zero extension and a request/acknowledge handshake. It holds the core in stall until the memory responds or a timeout fires. It sits between the execute stage outputs (address = ALU result, store data = rs2, funct3 from the instruction) and the data memory.

## Interface
- TIMEOUT_CYCLES, 255: WAIT-state cycles without `mem_ack` before the access is aborted with an error; legal range 1..65535.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the core; honoured only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width field: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  effective byte address.
- wdata  in  32  store data (rs2).
- busy  out  1  stall to core; high from the cycle after an accepted start through WAIT.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while `done` is high, held until the next start.
- err  out  1  high with `done` when the access failed.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 for loads.
- mem_ack  in  1  responder acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states:
  - IDLE: `start` latches `is_store`, `funct3`, `addr` and `wdata`. A legal access goes to WAIT; an illegal one goes to DONE with `err` set.
  - WAIT: `mem_req` is held high with all bus fields stable. On `mem_ack`, go to DONE. When the timeout counter reaches TIMEOUT_CYCLES, go to DONE with `err` set and `rdata` = 0.
  - DONE: `done` = 1 for one cycle, then return to IDLE.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value other than 000, 001, 010.
  - No bus transaction is issued.
- Store lanes:
  - sb: wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - sh: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated ×2.
  - sw: wstrb = 4'b1111.
- Loads:
  - Select the byte at addr[1:0], or the halfword at addr[1].
  - b/h sign-extend; bu/hu zero-extend; w passes the word through.
- `start` outside IDLE is ignored and nothing is queued.
- The timeout counter clears on entry to WAIT and saturates; its width is 16 bits.

## Timing
- Reset (asynchronous, `rst` = 0): state IDLE; all outputs 0, including `rdata`; counter 0. Reset during WAIT drops `mem_req` immediately; the in-flight access is abandoned with no `done`.
- All outputs are registered.
- Access start: `start` sampled at edge 0 → `busy` and `mem_req` high from cycle 1.
- `mem_ack` may arrive in cycle 1 (zero-wait responder).
- Completion: ack sampled at edge k → `done` high in cycle k+1; `busy` and `mem_req` low in cycle k+1. Minimum start-to-done latency is 2 cycles.
- Illegal or misaligned access: `done` and `err` are high in cycle 1; `busy` and `mem_req` never assert.
- Timeout: `done` and `err` are high TIMEOUT_CYCLES+1 cycles after `mem_req` rises.
- Back-to-back: a `start` in the DONE cycle is ignored. The earliest next start is the cycle after `done`.
- Late ack: an ack arriving in the same cycle the timeout counter reaches its limit counts as success.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses are halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - They go to DONE with `err` = 1 and no bus request.
- MISALIGN_TRAP_EN undefined:
  - No misalignment check.
  - Halfword uses addr[1] only; word ignores addr[1:0].
  - The access proceeds normally.

## Test plan
- sb, addr = 0x1003, wdata = 0x000000A5, ack in cycle 1 → mem_addr = 0x1000, wstrb = 4'b1000, mem_wdata = 0xA5A5A5A5; `done` in cycle 2, `err` = 0.
- Byte load at 0x2001: lb with mem_rdata = 0x12348000 → rdata = 0xFFFFFF80. Repeat as lbu → rdata = 0x00000080.
- Halfword load at 0x2002: lh with mem_rdata = 0x8001FFFF, ack delayed 5 cycles → `busy` high for 6 cycles; rdata = 0xFFFF8001.
- No ack, TIMEOUT_CYCLES = 4 → `done` and `err` = 1 in cycle 6; rdata = 0; `mem_req` low afterwards.
- lw at 0x3002:
  - With MISALIGN_TRAP_EN: `done` and `err` in cycle 1, `mem_req` never high.
  - Without it: mem_addr = 0x3000, `err` = 0.
- Reset during WAIT, then a new sw at 0x40 → all outputs 0 while `rst` = 0. The new access completes normally with wstrb = 4'b1111.

Source files
------------

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: multi-cycle load/store unit between the execute stage and the
// data-memory bus. Handles byte-lane steering, sign/zero extension, a
// request/acknowledge handshake and a saturating 16-bit timeout.
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned halfword/word
// accesses without issuing a bus request.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic        req_legal;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign tmo_hit = (tmo_cnt == TMO_LIMIT);

  // Decide whether the request presented with start may go to the bus
  always_comb begin
    req_legal = 1'b0;
    if (is_store) begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      req_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end
`ifdef MISALIGN_TRAP_EN
    if ((funct3[1:0] == 2'b01) && addr[0]) req_legal = 1'b0;
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) req_legal = 1'b0;
`endif
  end

  // Steer store data onto the byte lanes and build the byte enables
  always_comb begin
    req_wstrb = 4'b1111;
    req_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        req_wstrb = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
      end
      default: begin
        req_wstrb = 4'b1111;
        req_wdata = wdata;
      end
    endcase
  end

  // Pick the addressed byte/halfword from the read word and extend it
  always_comb begin
    byte_sel = mem_rdata[{lat_off, 3'b000} +: 8];
    half_sel = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = req_legal ? ST_WAIT : ST_DONE;
      ST_WAIT: if (mem_ack || tmo_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Registered outputs, latched request fields and the timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      tmo_cnt    <= 16'h0;
      lat_store  <= 1'b0;
      lat_funct3 <= 3'h0;
      lat_off    <= 2'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_store  <= is_store;
            lat_funct3 <= funct3;
            lat_off    <= addr[1:0];
            if (req_legal) begin
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
              mem_wstrb <= is_store ? req_wstrb : 4'h0;
              tmo_cnt   <= 16'h0;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ack || tmo_hit) begin
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            done      <= 1'b1;
            err       <= !mem_ack;
            rdata     <= (mem_ack && !lat_store) ? load_val : 32'h0;
          end else if (tmo_cnt != 16'hFFFF) begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          err  <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
